// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared encodings for the stack processor control unit
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_ALU   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_BZ    = 4'h7;
  localparam logic [3:0] OP_CALL  = 4'h8;
  localparam logic [3:0] OP_RET   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] PC_SRC_RSTACK = 3'd0;
  localparam logic [2:0] PC_SRC_REL    = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_INC    = 3'd4;

  localparam logic [1:0] SOP_NOP     = 2'd0;
  localparam logic [1:0] SOP_PUSH    = 2'd1;
  localparam logic [1:0] SOP_REPLACE = 2'd2;
  localparam logic [1:0] SOP_POP     = 2'd3;

  localparam logic [1:0] DSRC_ALU = 2'd0;
  localparam logic [1:0] DSRC_IMM = 2'd1;
  localparam logic [1:0] DSRC_MEM = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_STACK   = 2'd2;
  localparam logic [1:0] TRAP_OVF     = 2'd3;

endpackage

// File: rtl/stack_ctrl_decode.sv
// rtl/stack_ctrl_decode.sv - IR opcode class, legality and stack preconditions
module stack_ctrl_decode
  import stack_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic        legal,
  output logic        need_dspace,
  output logic        need_ddata,
  output logic        need_rspace,
  output logic        need_rdata
);

  // classify the opcode and record which stack condition it depends on
  always_comb begin
    opcode      = ir[15:12];
    legal       = 1'b1;
    need_dspace = 1'b0;
    need_ddata  = 1'b0;
    need_rspace = 1'b0;
    need_rdata  = 1'b0;
    case (ir[15:12])
      OP_PUSHI, OP_LOAD:                need_dspace = 1'b1;
      OP_POP, OP_ALU, OP_STORE, OP_BZ:  need_ddata  = 1'b1;
      OP_CALL:                          need_rspace = 1'b1;
      OP_RET:                           need_rdata  = 1'b1;
      OP_NOP, OP_JUMP, OP_HALT:         legal       = 1'b1;
      default:                          legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_control_unit.sv
// rtl/stack_control_unit.sv - multi-cycle control FSM for the stack processor datapath
module stack_control_unit
  import stack_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [15:0]      inst,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             DStackFull,
  input  logic             DStackEmpty,
  input  logic             RStackFull,
  input  logic             RStackEmpty,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       PCControl,
  output logic [1:0]       RStackOP,
  output logic [1:0]       DStackOP,
  output logic [2:0]       ALUOp,
  output logic [1:0]       DStackSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Halted,
  output logic             Trap,
  output logic [1:0]       TrapCode,
  output logic [CNT_W-1:0] InstrCount
);

  state_e             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [1:0]         trap_code_q, trap_code_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;

  logic [3:0]         opcode;
  logic               legal;
  logic               need_dspace, need_ddata, need_rspace, need_rdata;
  logic               stack_fault;
  logic               retire;

  stack_ctrl_decode u_decode (
    .ir          (ir_q),
    .opcode      (opcode),
    .legal       (legal),
    .need_dspace (need_dspace),
    .need_ddata  (need_ddata),
    .need_rspace (need_rspace),
    .need_rdata  (need_rdata)
  );

  assign stack_fault = (need_dspace & DStackFull)  | (need_ddata & DStackEmpty) |
                       (need_rspace & RStackFull)  | (need_rdata & RStackEmpty);

  // state, instruction register, sticky trap cause and retired-instruction counter
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_START;
      ir_q          <= 16'h0000;
      trap_code_q   <= TRAP_NONE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      trap_code_q   <= trap_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  // next state and datapath strobes, decoded from state and IR
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    trap_code_d = trap_code_q;
    retire      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCControl   = PC_SRC_RSTACK;
    RStackOP    = SOP_NOP;
    DStackOP    = SOP_NOP;
    ALUOp       = 3'd0;
    DStackSrc   = DSRC_ALU;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        IRWrite   = 1'b1;
        ir_d      = inst;
        PCWrite   = 1'b1;
        PCControl = PC_SRC_INC;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        if (!legal) begin
          state_d     = ST_TRAP;
          trap_code_d = TRAP_ILLEGAL;
        end else if (stack_fault) begin
          state_d     = ST_TRAP;
          trap_code_d = TRAP_STACK;
        end else begin
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
        case (opcode)
          OP_PUSHI: begin
            DStackOP  = SOP_PUSH;
            DStackSrc = DSRC_IMM;
          end
          OP_POP: DStackOP = SOP_POP;
          OP_ALU: begin
            ALUOp = ir_q[2:0];
            // an overflowing result is discarded: the stacks stay untouched
            if (TRAP_ON_OVF && Overflow) begin
              state_d     = ST_TRAP;
              trap_code_d = TRAP_OVF;
              retire      = 1'b0;
            end else begin
              DStackOP = SOP_POP;
            end
          end
          OP_LOAD, OP_STORE: begin
            state_d = ST_MEM;
            retire  = 1'b0;
          end
          OP_JUMP: begin
            PCWrite   = 1'b1;
            PCControl = PC_SRC_REL;
          end
          OP_BZ: begin
            DStackOP  = SOP_POP;
            PCWrite   = Zero;
            PCControl = PC_SRC_BRANCH;
          end
          OP_CALL: begin
            // PC already points past the CALL, so the pushed value is the return address
            RStackOP  = SOP_PUSH;
            PCWrite   = 1'b1;
            PCControl = PC_SRC_REL;
          end
          OP_RET: begin
            RStackOP  = SOP_POP;
            PCWrite   = 1'b1;
            PCControl = PC_SRC_RSTACK;
          end
          OP_HALT: state_d = ST_HALT;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        MemRead  = (opcode == OP_LOAD);
        MemWrite = (opcode != OP_LOAD);
        if (MemReady) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
          if (opcode == OP_LOAD) begin
            DStackOP  = SOP_REPLACE;
            DStackSrc = DSRC_MEM;
          end else begin
            DStackOP  = SOP_POP;
          end
        end
      end
      default: state_d = state_q;
    endcase
    instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
  end

  assign Halted     = (state_q == ST_HALT);
  assign Trap       = (state_q == ST_TRAP);
  assign TrapCode   = trap_code_q;
  assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_stack_control_unit.sv
// tb/tb_stack_control_unit.sv - randomized self-checking bench for stack_control_unit
module tb_stack_control_unit;

  localparam int CW   = 4;
  localparam int DCAP = 4;
  localparam int RCAP = 4;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [15:0]   inst = 16'h0;
  logic          Zero = 1'b0, Overflow = 1'b0, MemReady = 1'b0;
  logic          DStackFull, DStackEmpty, RStackFull, RStackEmpty;
  logic          IRWrite, PCWrite, MemRead, MemWrite, Halted, Trap;
  logic [2:0]    PCControl, ALUOp;
  logic [1:0]    RStackOP, DStackOP, DStackSrc, TrapCode;
  logic [CW-1:0] InstrCount;
  logic [15:0]   strobes;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] pc;
  int          dsp;
  int          rsz;
  logic [15:0] rq[$];
  int          cnt;
  int          last_kind;
  int          last_code;

  assign DStackFull  = (dsp == DCAP);
  assign DStackEmpty = (dsp == 0);
  assign RStackFull  = (rsz == RCAP);
  assign RStackEmpty = (rsz == 0);
  assign strobes = {IRWrite, PCWrite, PCControl, RStackOP, DStackOP, ALUOp, DStackSrc, MemRead, MemWrite};

  always #5 CLK = ~CLK;

  stack_control_unit #(.CNT_W(CW), .TRAP_ON_OVF(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .inst(inst), .Zero(Zero), .Overflow(Overflow),
    .DStackFull(DStackFull), .DStackEmpty(DStackEmpty),
    .RStackFull(RStackFull), .RStackEmpty(RStackEmpty), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCControl(PCControl), .RStackOP(RStackOP),
    .DStackOP(DStackOP), .ALUOp(ALUOp), .DStackSrc(DStackSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .Halted(Halted), .Trap(Trap), .TrapCode(TrapCode),
    .InstrCount(InstrCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] sext(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  // datapath stand-in: react to one cycle of strobes
  task automatic apply_strobes(input logic [15:0] ins, inout logic [2:0] alu_seen,
                               inout logic [1:0] src_seen);
    if (RStackOP == 2'd1) rq.push_back(pc);
    if (PCWrite) begin
      case (PCControl)
        3'd0:    pc = (rq.size() > 0) ? rq[$] : 16'h0;
        3'd1,
        3'd2:    pc = pc + sext(ins[11:0]);
        3'd4:    pc = pc + 16'd2;
        default: pc = 16'hdead;
      endcase
    end
    if (RStackOP == 2'd3 && rq.size() > 0) void'(rq.pop_back());
    rsz = rq.size();
    if (DStackOP == 2'd1) dsp++;
    if (DStackOP == 2'd3 && dsp > 0) dsp--;
    if (DStackOP == 2'd1 || DStackOP == 2'd2) src_seen = DStackSrc;
    alu_seen = alu_seen | ALUOp;
  endtask

  task automatic wait_fetch(input string tag);
    int w = 0;
    do begin
      @(negedge CLK); #1; w++;
    end while (!IRWrite && w < 10);
    chk(tag, w, 1);
  endtask

  task automatic do_reset();
    Reset = 1'b0; MemReady = 1'b0; Overflow = 1'b0; Zero = 1'($urandom);
    #1;
    chk("reset_async_outs", {12'h0, strobes, Halted, Trap, TrapCode}, 32'h0);
    pc = 16'h0; dsp = 0; rq.delete(); rsz = 0; cnt = 0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", {12'h0, strobes, Halted, Trap, TrapCode}, 32'h0);
    chk("reset_count", 32'(InstrCount), 32'h0);
    Reset = 1'b1;
    wait_fetch("fetch_after_reset");
  endtask

  // entered at the sample point of a FETCH cycle; leaves at the next FETCH, HALT or TRAP
  task automatic run_instr(input logic [15:0] ins, input bit z = 1'b0, input bit ov = 1'b0,
                           input int dly = 1);
    logic [3:0]  op;
    logic [15:0] imm, e_pc;
    int e_kind, e_code, e_cyc, e_dsp, e_rsz, e_cnt, e_mem, e_alu, e_src, cyc, memc, kind;
    bit fault, done;
    logic [2:0] alu_seen;
    logic [1:0] src_seen;
    op = ins[15:12]; imm = sext(ins[11:0]);
    e_kind = 0; e_code = 0; e_cyc = 3; e_dsp = dsp; e_rsz = rsz;
    e_cnt = (cnt + 1) % (1 << CW); e_mem = 0; e_alu = 0; e_src = 0;
    e_pc = pc + 16'd2; fault = 1'b0;
    case (op)
      4'h0: e_kind = 0;
      4'h1: if (dsp == DCAP) fault = 1'b1; else begin e_dsp = dsp + 1; e_src = 1; end
      4'h2: if (dsp == 0) fault = 1'b1; else e_dsp = dsp - 1;
      4'h3: if (dsp == 0) fault = 1'b1;
            else begin
              e_alu = int'(ins[2:0]);
              if (ov) begin e_kind = 2; e_code = 3; e_cnt = cnt; end
              else e_dsp = dsp - 1;
            end
      4'h4: if (dsp == DCAP) fault = 1'b1; else begin e_cyc = 3 + dly; e_mem = dly; e_src = 2; end
      4'h5: if (dsp == 0) fault = 1'b1; else begin e_dsp = dsp - 1; e_cyc = 3 + dly; e_mem = dly; end
      4'h6: e_pc = pc + 16'd2 + imm;
      4'h7: if (dsp == 0) fault = 1'b1;
            else begin e_dsp = dsp - 1; if (z) e_pc = pc + 16'd2 + imm; end
      4'h8: if (rsz == RCAP) fault = 1'b1; else begin e_rsz = rsz + 1; e_pc = pc + 16'd2 + imm; end
      4'h9: if (rsz == 0) fault = 1'b1; else begin e_rsz = rsz - 1; e_pc = rq[$]; end
      4'hF: e_kind = 1;
      default: begin e_kind = 2; e_code = 1; e_cyc = 2; e_cnt = cnt; end
    endcase
    if (fault) begin
      e_kind = 2; e_code = 2; e_cyc = 2; e_cnt = cnt;
      e_dsp = dsp; e_rsz = rsz; e_mem = 0; e_src = 0; e_alu = 0;
    end

    inst = ins; Zero = z; Overflow = ov;
    alu_seen = 3'd0; src_seen = 2'd0; memc = 0; done = 1'b0;
    apply_strobes(ins, alu_seen, src_seen);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      if (MemRead | MemWrite) begin memc++; MemReady = (memc >= dly); end
      else MemReady = 1'($urandom);
      #1;
      if (IRWrite | Halted | Trap) done = 1'b1;
      else begin apply_strobes(ins, alu_seen, src_seen); cyc++; end
    end
    kind = Halted ? 1 : (Trap ? 2 : 0);
    chk($sformatf("op%h_end_kind", op), kind, e_kind);
    chk($sformatf("op%h_cycles", op), cyc, e_cyc);
    chk($sformatf("op%h_pc", op), 32'(pc), 32'(e_pc));
    chk($sformatf("op%h_dstack_depth", op), dsp, e_dsp);
    chk($sformatf("op%h_rstack_depth", op), rsz, e_rsz);
    chk($sformatf("op%h_instr_count", op), 32'(InstrCount), e_cnt);
    chk($sformatf("op%h_trap_code", op), 32'(TrapCode), e_code);
    chk($sformatf("op%h_mem_cycles", op), memc, e_mem);
    chk($sformatf("op%h_aluop", op), 32'(alu_seen), e_alu);
    chk($sformatf("op%h_dstack_src", op), 32'(src_seen), e_src);
    cnt = e_cnt; last_kind = e_kind; last_code = e_code;
  endtask

  task automatic check_absorb();
    repeat (3) begin
      @(negedge CLK);
      MemReady = 1'($urandom); Zero = 1'($urandom); Overflow = 1'($urandom);
      #1;
    end
    chk("absorb_strobes", 32'(strobes), 32'h0);
    chk("absorb_state", {28'h0, Halted, Trap, TrapCode},
        {28'h0, last_kind == 1, last_kind == 2, 2'(last_code)});
    chk("absorb_count", 32'(InstrCount), cnt);
  endtask

  task automatic reset_in_mem();
    logic [2:0] a;
    logic [1:0] s;
    a = 3'd0; s = 2'd0;
    inst = 16'h4000; Zero = 1'b0; Overflow = 1'b0; MemReady = 1'b0;
    apply_strobes(inst, a, s);
    repeat (3) begin @(negedge CLK); MemReady = 1'b0; #1; end
    chk("mem_wait_read", 32'(MemRead), 32'h1);
    #2;
    do_reset();
    run_instr(16'h0000);
    run_instr(16'hF000);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    int          r;
    #2;
    do_reset();
    run_instr(16'h0000); run_instr(16'h0000); run_instr(16'hF000); check_absorb();

    do_reset();
    run_instr(16'h0000); run_instr(16'h0000); run_instr(16'h8008); run_instr(16'h9000);
    run_instr(16'hF000);

    do_reset();
    run_instr(16'h1005); run_instr(16'h1000);
    run_instr(16'h7010, 1'b1); run_instr(16'h7FF0, 1'b0);

    do_reset();
    run_instr(16'h4000, 1'b0, 1'b0, 3); run_instr(16'h1003); run_instr(16'h5000, 1'b0, 1'b0, 2);

    do_reset(); run_instr(16'hB000); check_absorb();
    do_reset(); run_instr(16'h9000); check_absorb();
    do_reset(); run_instr(16'h1001); run_instr(16'h3003, 1'b0, 1'b1); check_absorb();

    do_reset();
    repeat (18) run_instr(16'h0000);

    do_reset();
    reset_in_mem();

    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int k = 0; k < 30; k++) begin
        r = int'($urandom % 100);
        if (r < 4)      op = 4'hF;
        else if (r < 7) op = 4'hA + 4'($urandom % 5);
        else            op = 4'($urandom % 10);
        ins = {op, 12'($urandom)};
        run_instr(ins, 1'($urandom), ($urandom % 6) == 0, 1 + int'($urandom % 4));
        if (last_kind != 0) begin
          check_absorb();
          break;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
